// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

  // Which requester a pending response belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // One-entry tag captured at grant time and consumed in the response cycle.
  typedef struct packed {
    owner_e owner;
    logic   is_read;
    logic   err;
  } rsp_tag_t;

  localparam logic [31:0] IMEM_LIMIT_DEF = 32'h0000_0800;
  localparam logic [31:0] RAM_LIMIT_DEF  = 32'd10240;

  localparam rsp_tag_t TAG_IDLE = '{owner: OWN_NONE, is_read: 1'b0, err: 1'b0};

  // True when a byte address is on a 32-bit word boundary.
  function automatic logic word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

  // Response payload: only a legal read returns memory data, everything else is zero.
  function automatic logic [31:0] rsp_data(input rsp_tag_t tag, input logic [31:0] mem_out);
    logic [31:0] data;
    if (tag.is_read && !tag.err) begin
      data = mem_out;
    end else begin
      data = 32'h0000_0000;
    end
    return data;
  endfunction

endpackage

// File: rtl/mem_addr_check.sv
// Address legality check: word aligned and strictly below the region limit.
module mem_addr_check
  import mem_arbiter_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [31:0] limit,
  output logic        legal
);

  // Legal only when aligned and inside the region.
  always_comb begin
    legal = word_aligned(addr) && (addr < limit);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-cycle memory.
// Grants are combinational; responses come back exactly one cycle later.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [31:0] IMEM_LIMIT = IMEM_LIMIT_DEF,
  parameter logic [31:0] RAM_LIMIT  = RAM_LIMIT_DEF,
  parameter int unsigned STARVE_MAX = 32'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_en,
  output logic        mem_r_w,
  output logic [31:0] mem_address,
  output logic [31:0] mem_in,
  input  logic [31:0] mem_out
);

  logic        if_legal_s;
  logic        d_legal_s;
  logic        at_max_s;
  logic        if_gnt_s;
  logic        d_gnt_s;
  logic [31:0] starve_cnt_r;
  rsp_tag_t    tag_r;

  mem_addr_check u_if_check (
    .addr  (if_addr),
    .limit (IMEM_LIMIT),
    .legal (if_legal_s)
  );

  mem_addr_check u_d_check (
    .addr  (d_addr),
    .limit (RAM_LIMIT),
    .legal (d_legal_s)
  );

  assign at_max_s = (starve_cnt_r == STARVE_MAX);

  // Pick the winner: data by default, fetch once it has waited long enough; nothing while in reset.
  always_comb begin
    if_gnt_s = 1'b0;
    d_gnt_s  = 1'b0;
    if (rst_n) begin
      if (if_req && (!d_req || at_max_s)) begin
        if_gnt_s = 1'b1;
      end else if (d_req) begin
        d_gnt_s = 1'b1;
      end else begin
        if_gnt_s = 1'b0;
      end
    end else begin
      d_gnt_s = 1'b0;
    end
  end

  assign if_gnt = if_gnt_s;
  assign d_gnt  = d_gnt_s;

  // Drive the memory port only for a legal granted access; idle and illegal cycles stay all-zero.
  always_comb begin
    mem_en      = 1'b0;
    mem_r_w     = 1'b0;
    mem_address = 32'h0000_0000;
    mem_in      = 32'h0000_0000;
    if (if_gnt_s && if_legal_s) begin
      mem_en      = 1'b1;
      mem_address = if_addr;
    end else if (d_gnt_s && d_legal_s) begin
      mem_en      = 1'b1;
      mem_r_w     = d_we;
      mem_address = d_addr;
      mem_in      = d_wdata;
    end else begin
      mem_en = 1'b0;
    end
  end

  // Count data grants that overtook a waiting fetch; any fetch grant or idle fetch side clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_r <= 32'd0;
    end else if (!if_req || if_gnt_s) begin
      starve_cnt_r <= 32'd0;
    end else if (d_gnt_s && !at_max_s) begin
      starve_cnt_r <= starve_cnt_r + 32'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Remember who was granted and how the response must look; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_r <= TAG_IDLE;
    end else if (if_gnt_s) begin
      tag_r <= '{owner: OWN_IF, is_read: 1'b1, err: !if_legal_s};
    end else if (d_gnt_s) begin
      tag_r <= '{owner: OWN_D, is_read: !d_we, err: !d_legal_s};
    end else begin
      tag_r <= TAG_IDLE;
    end
  end

  // Steer the one pending response to its owner; the other port sees zeros.
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = 32'h0000_0000;
    if_err    = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = 32'h0000_0000;
    d_err     = 1'b0;
    case (tag_r.owner)
      OWN_IF: begin
        if_rvalid = 1'b1;
        if_rdata  = rsp_data(tag_r, mem_out);
        if_err    = tag_r.err;
      end
      OWN_D: begin
        d_rvalid = 1'b1;
        d_rdata  = rsp_data(tag_r, mem_out);
        d_err    = tag_r.err;
      end
      default: begin
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized plus directed bench for mem_arbiter against a behavioural model.
module tb_mem_arbiter;

  localparam logic [31:0] IMEM_LIM = 32'h0000_0800;
  localparam logic [31:0] RAM_LIM  = 32'd10240;
  localparam int          STARVE   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_en, mem_r_w;
  logic [31:0] mem_address, mem_in;
  logic [31:0] mem_out;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_r_w(mem_r_w), .mem_address(mem_address),
    .mem_in(mem_in), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // Environment memory: registered read, garbage on mem_out when not reading.
  logic [31:0] env_mem [0:4095];
  initial for (int i = 0; i < 4096; i++) env_mem[i] = 32'h0;
  always @(posedge clk) begin
    if (mem_en && !mem_r_w) mem_out <= env_mem[mem_address[13:2]];
    else mem_out <= $urandom;
    if (mem_en && mem_r_w) env_mem[mem_address[13:2]] <= mem_in;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] ref_mem [int];
  int          streak = 0;
  bit          drv_rst_n = 1'b0;
  bit          pend_if = 1'b0, pend_d = 1'b0, pd_we = 1'b0;
  logic [31:0] pif_addr = 32'h0, pd_addr = 32'h0, pd_wdata = 32'h0;
  bit          e_if_v = 1'b0, e_if_err = 1'b0, e_d_v = 1'b0, e_d_err = 1'b0;
  logic [31:0] e_if_rd = 32'h0, e_d_rd = 32'h0;
  bit          last_if_gnt = 1'b0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
  endfunction

  // One clock cycle: drive pending requests, check against the model, advance the model.
  task automatic run_cycle(input bit rst_after);
    bit lg_if, lg_d, eg_if, eg_d;
    bit n_if_v, n_if_err, n_d_v, n_d_err;
    logic [31:0] n_if_rd, n_d_rd;
    @(posedge clk); #1;
    rst_n = drv_rst_n;
    if_req = pend_if; if_addr = pif_addr;
    d_req = pend_d; d_we = pd_we; d_addr = pd_addr; d_wdata = pd_wdata;
    #2;
    lg_if = (pif_addr[1:0] == 2'b00) && (pif_addr < IMEM_LIM);
    lg_d  = (pd_addr[1:0] == 2'b00) && (pd_addr < RAM_LIM);
    eg_if = drv_rst_n && pend_if && (!pend_d || streak == STARVE);
    eg_d  = drv_rst_n && pend_d && !eg_if;
    chk("if_gnt", 32'(if_gnt), 32'(eg_if));
    chk("d_gnt", 32'(d_gnt), 32'(eg_d));
    if (eg_if) begin
      chk("mem_en_if", 32'(mem_en), 32'(lg_if));
      if (lg_if) begin
        chk("mem_rw_if", 32'(mem_r_w), 32'h0);
        chk("mem_addr_if", mem_address, pif_addr);
        chk("mem_in_if", mem_in, 32'h0);
      end
    end else if (eg_d) begin
      chk("mem_en_d", 32'(mem_en), 32'(lg_d));
      if (lg_d) begin
        chk("mem_rw_d", 32'(mem_r_w), 32'(pd_we));
        chk("mem_addr_d", mem_address, pd_addr);
        chk("mem_in_d", mem_in, pd_wdata);
      end
    end else begin
      chk("mem_idle", {mem_address[31:2], mem_address[1:0] | {mem_en, mem_r_w}} | mem_in, 32'h0);
      chk("mem_en_idle", 32'(mem_en), 32'h0);
    end
    chk("if_rvalid", 32'(if_rvalid), 32'(e_if_v));
    chk("if_err", 32'(if_err), 32'(e_if_err));
    chk("if_rdata", if_rdata, e_if_rd);
    chk("d_rvalid", 32'(d_rvalid), 32'(e_d_v));
    chk("d_err", 32'(d_err), 32'(e_d_err));
    chk("d_rdata", d_rdata, e_d_rd);
    last_if_gnt = if_gnt;
    n_if_v = 0; n_if_err = 0; n_if_rd = 32'h0;
    n_d_v = 0; n_d_err = 0; n_d_rd = 32'h0;
    if (!rst_after) begin
      if (eg_if) begin
        n_if_v = 1; n_if_err = !lg_if;
        n_if_rd = lg_if ? ref_rd(pif_addr) : 32'h0;
        pend_if = 0;
      end
      if (eg_d) begin
        n_d_v = 1; n_d_err = !lg_d;
        n_d_rd = (lg_d && !pd_we) ? ref_rd(pd_addr) : 32'h0;
        if (lg_d && pd_we) ref_mem[int'(pd_addr)] = pd_wdata;
        pend_d = 0;
      end
      if (!drv_rst_n || !if_req || eg_if) streak = 0;
      else if (eg_d && streak < STARVE) streak++;
    end else begin
      #1;
      rst_n = 1'b0; drv_rst_n = 1'b0;
      streak = 0; pend_if = 0; pend_d = 0;
    end
    e_if_v = n_if_v; e_if_err = n_if_err; e_if_rd = n_if_rd;
    e_d_v = n_d_v; e_d_err = n_d_err; e_d_rd = n_d_rd;
  endtask

  function automatic logic [31:0] pick_addr(input bit is_d);
    logic [31:0] lim;
    lim = is_d ? RAM_LIM : IMEM_LIM;
    case ($urandom_range(0, 5))
      0, 1: return {$urandom_range(0, 511), 2'b00};
      2:    return is_d ? 32'({$urandom_range(0, 2559), 2'b00}) : 32'({$urandom_range(0, 511), 2'b00});
      3:    return {$urandom_range(0, 511), 2'b00} | 32'($urandom_range(1, 3));
      4:    return lim - 32'd4;
      default: return lim + 32'({$urandom_range(0, 63), 2'b00});
    endcase
  endfunction

  logic [5:0] hist;

  initial begin
    // Reset state
    drv_rst_n = 1'b0;
    repeat (2) run_cycle(1'b0);
    drv_rst_n = 1'b1;
    run_cycle(1'b0);

    // Store then load at 0x800
    pend_d = 1; pd_we = 1; pd_addr = 32'h800; pd_wdata = 32'hDEADBEEF;
    run_cycle(1'b0);
    pend_d = 1; pd_we = 0; pd_addr = 32'h800; pd_wdata = 32'h0;
    run_cycle(1'b0);
    chk("st_rsp_err", 32'(d_err), 32'h0);
    chk("st_rsp_rdata", d_rdata, 32'h0);
    run_cycle(1'b0);
    chk("ld_rsp_rdata", d_rdata, 32'hDEADBEEF);

    // Single fetch at 0x10 after seeding that word
    pend_d = 1; pd_we = 1; pd_addr = 32'h10; pd_wdata = 32'h1234_5678;
    run_cycle(1'b0);
    pend_if = 1; pif_addr = 32'h10;
    run_cycle(1'b0);
    run_cycle(1'b0);
    chk("fetch_rdata", if_rdata, 32'h1234_5678);

    // Illegal accesses
    pend_if = 1; pif_addr = 32'h800; run_cycle(1'b0); run_cycle(1'b0);
    pend_d = 1; pd_we = 0; pd_addr = 32'h802; run_cycle(1'b0); run_cycle(1'b0);
    pend_d = 1; pd_we = 1; pd_addr = 32'h2800; pd_wdata = 32'hA5A5_A5A5; run_cycle(1'b0); run_cycle(1'b0);

    // Reset in the cycle after a load grant
    pend_d = 1; pd_we = 0; pd_addr = 32'h100;
    run_cycle(1'b1);
    pend_d = 1; pd_we = 1; pd_addr = 32'h104; pd_wdata = 32'hFFFF_FFFF;
    run_cycle(1'b0);
    pend_d = 0; drv_rst_n = 1'b1;
    run_cycle(1'b0);

    // Contention: both held high, fetch gets every third slot
    hist = 6'b0;
    for (int k = 0; k < 6; k++) begin
      pend_if = 1; pif_addr = 32'h20;
      pend_d = 1; pd_we = 0; pd_addr = 32'h40;
      run_cycle(1'b0);
      hist = {hist[4:0], last_if_gnt};
    end
    chk("contend_order", 32'(hist), 32'h9);
    pend_if = 0; pend_d = 0;
    run_cycle(1'b0);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      if (!pend_if && ($urandom_range(0, 1) == 1)) begin
        pend_if = 1; pif_addr = pick_addr(1'b0);
      end
      if (!pend_d && ($urandom_range(0, 2) != 0)) begin
        pend_d = 1; pd_we = 1'($urandom_range(0, 1));
        pd_addr = pick_addr(1'b1); pd_wdata = $urandom;
      end
      run_cycle(1'b0);
    end
    pend_if = 0; pend_d = 0;
    repeat (2) run_cycle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
